// File: rtl/spart_bus_target.sv
// rtl/spart_bus_target.sv - SPART bus responder: baud divisor, 8N1 transmitter and receiver, rda/tbr flags
module spart_bus_target (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // baud generator
    logic [15:0] r_div;
    logic [15:0] r_baud_cnt;

    // transmitter
    state_t      r_tx_state;
    logic [7:0]  r_tx_hold;
    logic [7:0]  r_tx_shift;
    logic [3:0]  r_tx_tcnt;
    logic [2:0]  r_tx_idx;
    logic        r_tbr;
    logic        r_txd;

    // receiver
    logic        r_rx_sync1;
    logic        r_rx_sync2;
    state_t      r_rx_state;
    logic [3:0]  r_rx_tcnt;
    logic [2:0]  r_rx_idx;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_buf;
    logic        r_rda;
    logic        r_ovr;

    logic        w_tick;
    logic        w_wr;
    logic        w_rd;
    logic        w_rx_done;
    logic [7:0]  w_rdata;

    assign w_wr   = iocs & ~iorw;
    assign w_rd   = iocs & iorw;
    assign w_tick = (r_baud_cnt == 16'd0);

    // A byte is complete when the stop sample lands and the line is high
    assign w_rx_done = (r_rx_state == ST_STOP) && w_tick &&
                       (r_rx_tcnt == 4'd15) && r_rx_sync2;

    // Read data mux, combinational from the selected register
    always_comb begin
        w_rdata = 8'h00;
        case (ioaddr)
            2'b00:   w_rdata = r_rx_buf;
            2'b01:   w_rdata = {5'b0, r_ovr, r_tbr, r_rda};
            2'b10:   w_rdata = r_div[7:0];
            default: w_rdata = r_div[15:8];
        endcase
    end

    assign databus = w_rd ? w_rdata : 8'hzz;
    assign rda     = r_rda;
    assign tbr     = r_tbr;
    assign txd     = r_txd;

    // Divisor registers and free-running down-counter; a divisor write restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= 16'd0;
            r_baud_cnt <= 16'd0;
        end else if (w_wr && ioaddr == 2'b10) begin
            r_div[7:0] <= databus;
            r_baud_cnt <= {r_div[15:8], databus};
        end else if (w_wr && ioaddr == 2'b11) begin
            r_div[15:8] <= databus;
            r_baud_cnt  <= {databus, r_div[7:0]};
        end else if (w_tick) begin
            r_baud_cnt <= r_div;
        end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
        end
    end

    // Transmit holding register and frame sequencer; each bit spans 16 ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_hold  <= 8'h00;
            r_tx_shift <= 8'h00;
            r_tx_tcnt  <= 4'd0;
            r_tx_idx   <= 3'd0;
            r_tbr      <= 1'b1;
            r_txd      <= 1'b1;
        end else begin
            // A write while the holding register is full is dropped
            if (w_wr && ioaddr == 2'b00 && r_tbr) begin
                r_tx_hold <= databus;
                r_tbr     <= 1'b0;
            end
            case (r_tx_state)
                ST_IDLE: begin
                    if (!r_tbr) begin
                        r_tx_shift <= r_tx_hold;
                        r_tbr      <= 1'b1;
                        r_txd      <= 1'b0;
                        r_tx_tcnt  <= 4'd0;
                        r_tx_idx   <= 3'd0;
                        r_tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        if (r_tx_tcnt == 4'd15) begin
                            r_txd      <= r_tx_shift[0];
                            r_tx_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        if (r_tx_tcnt == 4'd15) begin
                            if (r_tx_idx == 3'd7) begin
                                r_txd      <= 1'b1;
                                r_tx_state <= ST_STOP;
                            end else begin
                                r_txd      <= r_tx_shift[1];
                                r_tx_shift <= r_tx_shift >> 1;
                                r_tx_idx   <= r_tx_idx + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        if (r_tx_tcnt == 4'd15) begin
                            r_tx_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Receive synchronizer and frame sequencer sampling mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_tcnt  <= 4'd0;
            r_rx_idx   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_sync1 <= rxd;
            r_rx_sync2 <= r_rx_sync1;
            case (r_rx_state)
                ST_IDLE: begin
                    if (w_tick && !r_rx_sync2) begin
                        r_rx_tcnt  <= 4'd0;
                        r_rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_rx_tcnt == 4'd7) begin
                            r_rx_tcnt <= 4'd0;
                            r_rx_idx  <= 3'd0;
                            // Line back high at mid-start means a glitch, not a frame
                            r_rx_state <= r_rx_sync2 ? ST_IDLE : ST_DATA;
                        end else begin
                            r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd15) begin
                            r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
                            r_rx_idx   <= r_rx_idx + 3'd1;
                            if (r_rx_idx == 3'd7) begin
                                r_rx_state <= ST_STOP;
                            end
                        end
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd15) begin
                            r_rx_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Receive buffer and flags; a completing byte outranks a same-edge read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_buf <= 8'h00;
            r_rda    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_rd && ioaddr == 2'b00) begin
                r_rda <= 1'b0;
            end
            if (w_rd && ioaddr == 2'b01) begin
                r_ovr <= 1'b0;
            end
            if (w_rx_done) begin
                r_rx_buf <= r_rx_shift;
                r_rda    <= 1'b1;
                if (r_rda) begin
                    r_ovr <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spart_bus_target.sv
// tb/tb_spart_bus_target.sv - self-checking bench for spart_bus_target with a frame-level reference model
module tb_spart_bus_target;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic       drv_en = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       rxd_drv = 1'b1;
    logic       loop = 1'b0;
    wire  [7:0] databus;
    wire        rda;
    wire        tbr;
    wire        txd;
    wire        rxd;

    int checks = 0;
    int failures = 0;

    assign databus = drv_en ? drv_data : 8'hzz;
    assign rxd     = loop ? txd : rxd_drv;

    spart_bus_target dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Ticks: one every div+1 cycles, restarted by a divisor write.
    // TX: a frame is 10 bit slots of 16 ticks counted after the load edge.
    // RX: ticks counted from the start-detect tick; samples at 8, 24..136, 152.
    int          m_rem;
    logic [15:0] m_div;
    bit          m_hold_full;
    logic [7:0]  m_hold;
    bit          m_tx_busy;
    int          m_tx_t;
    logic [7:0]  m_tx_byte;
    bit          m_s1, m_s2;
    bit          m_rx_act;
    int          m_rx_t;
    logic [7:0]  m_rx_bits;
    logic [7:0]  m_buf;
    bit          m_rda, m_ovr;

    function automatic logic m_txd();
        int slot;
        if (!m_tx_busy) return 1'b1;
        slot = m_tx_t / 16;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_tx_byte[slot-1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_rdata(input logic [1:0] a);
        case (a)
            2'b00:   return m_buf;
            2'b01:   return {5'b0, m_ovr, !m_hold_full, m_rda};
            2'b10:   return m_div[7:0];
            default: return m_div[15:8];
        endcase
    endfunction

    always @(posedge clk) begin
        bit tick, wr, rd, sync, old_full, old_rda, done;
        if (rst) begin
            m_rem = 0; m_div = 16'h0; m_hold_full = 0; m_hold = 8'h0;
            m_tx_busy = 0; m_tx_t = 0; m_tx_byte = 8'h0;
            m_s1 = 1; m_s2 = 1; m_rx_act = 0; m_rx_t = 0; m_rx_bits = 8'h0;
            m_buf = 8'h0; m_rda = 0; m_ovr = 0;
        end else begin
            tick = (m_rem == 0);
            wr = iocs && !iorw;
            rd = iocs && iorw;
            sync = m_s2;
            old_full = m_hold_full;
            old_rda = m_rda;
            done = 0;
            if (wr && ioaddr == 2'b10) begin
                m_div[7:0] = drv_data; m_rem = int'(m_div);
            end else if (wr && ioaddr == 2'b11) begin
                m_div[15:8] = drv_data; m_rem = int'(m_div);
            end else begin
                m_rem = tick ? int'(m_div) : m_rem - 1;
            end
            if (!m_tx_busy) begin
                if (old_full) begin
                    m_tx_busy = 1; m_tx_t = 0; m_tx_byte = m_hold; m_hold_full = 0;
                end
            end else if (tick) begin
                m_tx_t++;
                if (m_tx_t == 160) m_tx_busy = 0;
            end
            if (wr && ioaddr == 2'b00 && !old_full) begin
                m_hold = drv_data; m_hold_full = 1;
            end
            if (tick) begin
                if (!m_rx_act) begin
                    if (!sync) begin m_rx_act = 1; m_rx_t = 0; end
                end else begin
                    m_rx_t++;
                    if (m_rx_t == 8 && sync) m_rx_act = 0;
                    else if (m_rx_t >= 24 && m_rx_t <= 136 && (m_rx_t - 24) % 16 == 0)
                        m_rx_bits[(m_rx_t - 24) / 16] = sync;
                    else if (m_rx_t == 152) begin
                        m_rx_act = 0;
                        done = sync;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = rxd;
            if (rd && ioaddr == 2'b00) m_rda = 0;
            if (rd && ioaddr == 2'b01) m_ovr = 0;
            if (done) begin
                if (old_rda) m_ovr = 1;
                m_buf = m_rx_bits;
                m_rda = 1;
            end
        end
    end

    // Per-cycle comparison against the model, just after each active edge
    always @(posedge clk) begin
        #1;
        chk("cyc_txd", {15'b0, txd}, {15'b0, m_txd()});
        chk("cyc_tbr", {15'b0, tbr}, {15'b0, !m_hold_full});
        chk("cyc_rda", {15'b0, rda}, {15'b0, m_rda});
        if (iocs && iorw)  chk("cyc_rdata", {8'b0, databus}, {8'b0, m_rdata(ioaddr)});
        if (iocs && !iorw) chk("cyc_wbus", {8'b0, databus}, {8'b0, drv_data});
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1; iorw = 0; ioaddr = a; drv_en = 1; drv_data = d;
        @(negedge clk);
        iocs = 0; drv_en = 0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1; iorw = 1; ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        iocs = 0; iorw = 0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stopv, input int per);
        rxd_drv = 0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (per) @(negedge clk);
        end
        rxd_drv = stopv;
        repeat (per) @(negedge clk);
        rxd_drv = 1;
        repeat (per * 2) @(negedge clk);
    endtask

    task automatic wait_rda(input int bound);
        int n = 0;
        while (rda !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rda !== 1'b1) begin
            failures++;
            $display("FAIL wait_rda: rda not seen within %0d cycles", bound);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] rd;
        bit exp_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        repeat (2) @(negedge clk);
        rst = 0;

        // reset state
        chk("rst_txd", {15'b0, txd}, 16'h1);
        chk("rst_tbr", {15'b0, tbr}, 16'h1);
        chk("rst_rda", {15'b0, rda}, 16'h0);
        bus_read(2'b01, rd);
        chk("rst_status", {8'b0, rd}, 16'h02);

        // single frame at div=0
        bus_write(2'b00, 8'hA5);
        chk("a5_tbr_low", {15'b0, tbr}, 16'h0);
        @(negedge clk);
        chk("a5_tbr_back", {15'b0, tbr}, 16'h1);
        chk("a5_start", {15'b0, txd}, 16'h0);
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("a5_bit%0d", k), {15'b0, txd}, {15'b0, exp_a5[k]});
            repeat (16) @(negedge clk);
        end

        // back-to-back at div=3, third write dropped
        bus_write(2'b10, 8'h03);
        bus_write(2'b00, 8'h55);
        chk("b2b_tbr0", {15'b0, tbr}, 16'h0);
        bus_write(2'b00, 8'h0F);
        chk("b2b_held", {15'b0, tbr}, 16'h0);
        bus_write(2'b00, 8'hFF);
        chk("b2b_drop", {15'b0, tbr}, 16'h0);
        repeat (1400) @(negedge clk);
        chk("b2b_idle_tbr", {15'b0, tbr}, 16'h1);
        chk("b2b_idle_txd", {15'b0, txd}, 16'h1);

        // divisor readback, then loopback at a fast divisor
        bus_write(2'b10, 8'h16);
        bus_write(2'b11, 8'h05);
        bus_read(2'b10, rd);
        chk("div_lo", {8'b0, rd}, 16'h0016);
        bus_read(2'b11, rd);
        chk("div_hi", {8'b0, rd}, 16'h0005);
        bus_write(2'b10, 8'h02);
        bus_write(2'b11, 8'h00);
        loop = 1;
        bus_write(2'b00, 8'h3C);
        wait_rda(3000);
        repeat (3) @(negedge clk);
        bus_read(2'b00, rd);
        chk("loop_data", {8'b0, rd}, 16'h003C);
        chk("loop_rda_clr", {15'b0, rda}, 16'h0);
        repeat (600) @(negedge clk);
        loop = 0;

        // false start and framing error at div=0
        bus_write(2'b10, 8'h00);
        rxd_drv = 0;
        repeat (4) @(negedge clk);
        rxd_drv = 1;
        repeat (100) @(negedge clk);
        chk("glitch_rda", {15'b0, rda}, 16'h0);
        send_rx(8'h5A, 0, 16);
        repeat (40) @(negedge clk);
        chk("frame_err_rda", {15'b0, rda}, 16'h0);

        // overrun
        send_rx(8'h11, 1, 16);
        chk("ovr_first_rda", {15'b0, rda}, 16'h1);
        send_rx(8'h22, 1, 16);
        bus_read(2'b01, rd);
        chk("ovr_status1", {8'b0, rd}, 16'h07);
        bus_read(2'b01, rd);
        chk("ovr_status2", {8'b0, rd}, 16'h03);
        bus_read(2'b00, rd);
        chk("ovr_buf", {8'b0, rd}, 16'h22);

        // randomized traffic on both sides, checked by the model every cycle
        for (int it = 0; it < 12; it++) begin
            int d;
            d = $urandom_range(0, 2);
            bus_write(2'b10, 8'(d));
            fork
                begin
                    send_rx(8'($urandom), ($urandom_range(0, 5) != 0), 16 * (d + 1));
                end
                begin
                    repeat ($urandom_range(5, 15)) begin
                        case ($urandom_range(0, 4))
                            0: bus_write(2'b00, 8'($urandom));
                            1: bus_write(2'b01, 8'($urandom));
                            2: bus_read(2'($urandom_range(0, 3)), rd);
                            3: if ($urandom_range(0, 3) == 0) bus_write(2'b10, 8'($urandom_range(0, 2)));
                            default: repeat ($urandom_range(1, 30)) @(negedge clk);
                        endcase
                    end
                end
            join
        end

        // reset in the middle of a frame
        bus_write(2'b10, 8'h01);
        bus_write(2'b00, 8'h00);
        repeat (30) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_txd", {15'b0, txd}, 16'h1);
        chk("midrst_tbr", {15'b0, tbr}, 16'h1);
        chk("midrst_rda", {15'b0, rda}, 16'h0);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
